// File: rtl/sys_counter_unit.sv
// Execute-stage system unit: cycle, prescaled time and per-hart instret counters, plus
// SCALL/SBREAK trap responses. One request in, one registered response out, with
// valid/ready backpressure through a single-entry output register.

package sys_counter_pkg;

  // System operations emitted by the decoder.
  typedef enum logic [2:0] {
    SysopRdcycle,
    SysopRdcycleh,
    SysopRdtime,
    SysopRdtimeh,
    SysopRdinstret,
    SysopRdinstreth,
    SysopScall,
    SysopSbreak
  } t_sysop;

endpackage

module sys_counter_unit
  import sys_counter_pkg::*;
#(
  parameter int unsigned NUM_HARTS = 4,
  parameter int unsigned XLEN      = 32,
  parameter int unsigned CNT_WIDTH = 64,
  parameter int unsigned TIME_DIV  = 16,
  localparam int unsigned HART_W   = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  t_sysop               i_req_sysop,
  input  logic [HART_W-1:0]    i_req_hart,
  input  logic [NUM_HARTS-1:0] i_retire,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [XLEN-1:0]      o_rsp_data,
  output logic [HART_W-1:0]    o_rsp_hart,
  output logic                 o_rsp_trap,
  output logic                 o_rsp_cause
);

  localparam int unsigned PRE_W = (TIME_DIV > 1) ? $clog2(TIME_DIV) : 1;
  // Counters are zero-extended to two XLEN words so the low/high halves are plain slices,
  // independent of whether CNT_WIDTH is above or below XLEN.
  localparam int unsigned EXT_W = 2 * XLEN;

  typedef enum logic [0:0] {
    StEmpty,
    StFull
  } state_e;

  logic [CNT_WIDTH-1:0] cycle_q;
  logic [CNT_WIDTH-1:0] time_q;
  logic [PRE_W-1:0]     pre_q;
  logic                 time_tick;
  logic [CNT_WIDTH-1:0] instret_q [NUM_HARTS];

  state_e               state_q, state_d;
  logic                 rsp_valid;
  logic                 accept;

  logic [CNT_WIDTH-1:0] instret_sel;
  logic [EXT_W-1:0]     cnt_ext;
  logic                 rd_high;
  logic [XLEN-1:0]      rd_data;
  logic                 rd_trap;
  logic                 rd_cause;

  logic [XLEN-1:0]      rsp_data_q;
  logic [HART_W-1:0]    rsp_hart_q;
  logic                 rsp_trap_q;
  logic                 rsp_cause_q;

  // Prescaler wraps at TIME_DIV-1; with TIME_DIV=1 it stays at 0 and ticks every clock.
  assign time_tick = (pre_q == PRE_W'(TIME_DIV - 1));

  // Global cycle counter, prescaler and time counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cycle_q <= '0;
      pre_q   <= '0;
      time_q  <= '0;
    end else begin
      cycle_q <= cycle_q + CNT_WIDTH'(1);
      if (time_tick) begin
        pre_q  <= '0;
        time_q <= time_q + CNT_WIDTH'(1);
      end else begin
        pre_q <= pre_q + PRE_W'(1);
      end
    end
  end

  // Per-hart retired-instruction counters, one increment per retire bit per clock.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned h = 0; h < NUM_HARTS; h++) begin
        instret_q[h] <= '0;
      end
    end else begin
      for (int unsigned h = 0; h < NUM_HARTS; h++) begin
        instret_q[h] <= instret_q[h] + CNT_WIDTH'(i_retire[h]);
      end
    end
  end

  // Instret lookup by requesting hart; harts beyond NUM_HARTS read as zero.
  always_comb begin
    instret_sel = '0;
    if (32'(i_req_hart) < NUM_HARTS) begin
      instret_sel = instret_q[i_req_hart];
    end
  end

  // Operation decode and read-data selection from the current (pre-increment) registers.
  always_comb begin
    cnt_ext  = '0;
    rd_high  = 1'b0;
    rd_trap  = 1'b0;
    rd_cause = 1'b0;
    unique case (i_req_sysop)
      SysopRdcycle:    cnt_ext = EXT_W'(cycle_q);
      SysopRdcycleh: begin
        cnt_ext = EXT_W'(cycle_q);
        rd_high = 1'b1;
      end
      SysopRdtime:     cnt_ext = EXT_W'(time_q);
      SysopRdtimeh: begin
        cnt_ext = EXT_W'(time_q);
        rd_high = 1'b1;
      end
      SysopRdinstret:  cnt_ext = EXT_W'(instret_sel);
      SysopRdinstreth: begin
        cnt_ext = EXT_W'(instret_sel);
        rd_high = 1'b1;
      end
      SysopScall:      rd_trap = 1'b1;
      SysopSbreak: begin
        rd_trap  = 1'b1;
        rd_cause = 1'b1;
      end
    endcase
    rd_data = rd_high ? cnt_ext[EXT_W-1:XLEN] : cnt_ext[XLEN-1:0];
  end

  // Handshake: the output register can take a new entry when empty or being drained.
  assign rsp_valid   = (state_q == StFull);
  assign o_req_ready = !rsp_valid || i_rsp_ready;
  assign accept      = i_req_valid && o_req_ready;

  // Output-register occupancy state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // Occupancy next state: fill on accept, empty only when drained without a refill.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) state_d = StFull;
      end
      StFull: begin
        if (i_rsp_ready && !accept) state_d = StEmpty;
      end
    endcase
  end

  // Response payload, loaded on accept and held while the consumer stalls.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rsp_data_q  <= '0;
      rsp_hart_q  <= '0;
      rsp_trap_q  <= 1'b0;
      rsp_cause_q <= 1'b0;
    end else if (accept) begin
      rsp_data_q  <= rd_data;
      rsp_hart_q  <= i_req_hart;
      rsp_trap_q  <= rd_trap;
      rsp_cause_q <= rd_cause;
    end
  end

  assign o_rsp_valid = rsp_valid;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_hart  = rsp_hart_q;
  assign o_rsp_trap  = rsp_trap_q;
  assign o_rsp_cause = rsp_cause_q;

endmodule

// File: tb/tb_sys_counter_unit.sv
// Bench for sys_counter_unit: two instances (64-bit counters / 4 harts / div 16, and
// 8-bit counters / 5 harts / div 4) driven by directed steps; expectations come from an
// edge-count model and are queued at drive time, then checked as responses are consumed.

module tb_sys_counter_unit;
  import sys_counter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        req_valid_a, req_ready_a, rsp_valid_a, rsp_ready_a;
  t_sysop      req_sysop_a;
  logic [1:0]  req_hart_a, rsp_hart_a;
  logic [3:0]  retire_a;
  logic [31:0] rsp_data_a;
  logic        rsp_trap_a, rsp_cause_a;

  logic        req_valid_b, req_ready_b, rsp_valid_b, rsp_ready_b;
  t_sysop      req_sysop_b;
  logic [2:0]  req_hart_b, rsp_hart_b;
  logic [4:0]  retire_b;
  logic [31:0] rsp_data_b;
  logic        rsp_trap_b, rsp_cause_b;

  sys_counter_unit #(
    .NUM_HARTS(4), .XLEN(32), .CNT_WIDTH(64), .TIME_DIV(16)
  ) dut_a (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid_a), .o_req_ready(req_ready_a),
    .i_req_sysop(req_sysop_a), .i_req_hart(req_hart_a), .i_retire(retire_a),
    .o_rsp_valid(rsp_valid_a), .i_rsp_ready(rsp_ready_a), .o_rsp_data(rsp_data_a),
    .o_rsp_hart(rsp_hart_a), .o_rsp_trap(rsp_trap_a), .o_rsp_cause(rsp_cause_a)
  );

  sys_counter_unit #(
    .NUM_HARTS(5), .XLEN(32), .CNT_WIDTH(8), .TIME_DIV(4)
  ) dut_b (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid_b), .o_req_ready(req_ready_b),
    .i_req_sysop(req_sysop_b), .i_req_hart(req_hart_b), .i_retire(retire_b),
    .o_rsp_valid(rsp_valid_b), .i_rsp_ready(rsp_ready_b), .o_rsp_data(rsp_data_b),
    .o_rsp_hart(rsp_hart_b), .o_rsp_trap(rsp_trap_b), .o_rsp_cause(rsp_cause_b)
  );

  // Reference: unwrapped count of clock edges since release and retire counts per hart.
  longint unsigned edges;
  longint unsigned ret_a [4];
  longint unsigned ret_b [5];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edges <= 0;
      for (int h = 0; h < 4; h++) ret_a[h] <= 0;
      for (int h = 0; h < 5; h++) ret_b[h] <= 0;
    end else begin
      edges <= edges + 1;
      for (int h = 0; h < 4; h++) if (retire_a[h]) ret_a[h] <= ret_a[h] + 1;
      for (int h = 0; h < 5; h++) if (retire_b[h]) ret_b[h] <= ret_b[h] + 1;
    end
  end

  typedef struct {
    string       tag;
    logic [31:0] data;
    int          hart;
    bit          trap;
    bit          cause;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected read result from the edge-count model; time = edges / div.
  function automatic logic [31:0] exp_read(input bit sel_b, input t_sysop op, input int hart);
    longint unsigned mask, div, v;
    int nh;
    mask = sel_b ? 64'hFF : ~64'd0;
    div  = sel_b ? 64'd4 : 64'd16;
    nh   = sel_b ? 5 : 4;
    v    = 0;
    case (op)
      SysopRdcycle, SysopRdcycleh: v = edges & mask;
      SysopRdtime, SysopRdtimeh:   v = (edges / div) & mask;
      SysopRdinstret, SysopRdinstreth: begin
        if (hart < nh) begin
          if (sel_b) v = ret_b[hart] & mask;
          else       v = ret_a[hart] & mask;
        end
      end
      default: v = 0;
    endcase
    if (op == SysopRdcycleh || op == SysopRdtimeh || op == SysopRdinstreth) return v[63:32];
    return v[31:0];
  endfunction

  function automatic exp_t mk_exp(input string tag, input bit sel_b, input t_sysop op,
                                  input int hart);
    exp_t e;
    e.tag   = tag;
    e.data  = exp_read(sel_b, op, hart);
    e.hart  = hart;
    e.trap  = (op == SysopScall) || (op == SysopSbreak);
    e.cause = (op == SysopSbreak);
    return e;
  endfunction

  task automatic drv_a(input string tag, input t_sysop op, input int hart);
    req_valid_a = 1'b1;
    req_sysop_a = op;
    req_hart_a  = 2'(hart);
    q_a.push_back(mk_exp(tag, 1'b0, op, hart));
  endtask

  task automatic drv_b(input string tag, input t_sysop op, input int hart);
    req_valid_b = 1'b1;
    req_sysop_b = op;
    req_hart_b  = 3'(hart);
    q_b.push_back(mk_exp(tag, 1'b1, op, hart));
  endtask

  // A response is consumed on the coming edge when valid & ready: pop and compare it.
  task automatic monitor();
    exp_t e;
    if (rst_n && rsp_valid_a && rsp_ready_a) begin
      check("a_rsp_expected", 64'(q_a.size() != 0), 64'd1);
      if (q_a.size() != 0) begin
        e = q_a.pop_front();
        check({e.tag, "_data"}, 64'(rsp_data_a), 64'(e.data));
        check({e.tag, "_hart"}, 64'(rsp_hart_a), 64'(e.hart));
        check({e.tag, "_trap"}, 64'(rsp_trap_a), 64'(e.trap));
        if (e.trap) check({e.tag, "_cause"}, 64'(rsp_cause_a), 64'(e.cause));
      end
    end
    if (rst_n && rsp_valid_b && rsp_ready_b) begin
      check("b_rsp_expected", 64'(q_b.size() != 0), 64'd1);
      if (q_b.size() != 0) begin
        e = q_b.pop_front();
        check({e.tag, "_data"}, 64'(rsp_data_b), 64'(e.data));
        check({e.tag, "_hart"}, 64'(rsp_hart_b), 64'(e.hart));
        check({e.tag, "_trap"}, 64'(rsp_trap_b), 64'(e.trap));
        if (e.trap) check({e.tag, "_cause"}, 64'(rsp_cause_b), 64'(e.cause));
      end
    end
  endtask

  // Inputs change 2 time units after each rising edge; outputs are checked on the falling edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      monitor();
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] held;
    rst_n       = 1'b0;
    req_valid_a = 1'b0; req_sysop_a = SysopRdcycle; req_hart_a = '0;
    retire_a    = '0;   rsp_ready_a = 1'b1;
    req_valid_b = 1'b0; req_sysop_b = SysopRdcycle; req_hart_b = '0;
    retire_b    = '0;   rsp_ready_b = 1'b1;
    tick(2);

    check("rst_valid_a", 64'(rsp_valid_a), 64'd0);
    check("rst_data_a",  64'(rsp_data_a),  64'd0);
    check("rst_hart_a",  64'(rsp_hart_a),  64'd0);
    check("rst_trap_a",  64'(rsp_trap_a),  64'd0);
    check("rst_cause_a", 64'(rsp_cause_a), 64'd0);
    check("rst_valid_b", 64'(rsp_valid_b), 64'd0);

    rst_n = 1'b1;
    #1;
    check("rel_req_ready_a", 64'(req_ready_a), 64'd1);

    // Cycle read at counter 10, then the high half back-to-back.
    tick(10);
    drv_a("rdcycle10", SysopRdcycle, 0);
    tick(1);
    check("b2b_valid_1", 64'(rsp_valid_a), 64'd1);
    drv_a("rdcycleh", SysopRdcycleh, 0);
    tick(1);
    req_valid_a = 1'b0;
    tick(1);
    check("drain_valid", 64'(rsp_valid_a), 64'd0);

    // Hart-2 instret: the fifth retire lands on the accept edge and is not yet visible.
    retire_a = 4'b0100;
    tick(4);
    drv_a("instret_h2_first", SysopRdinstret, 2);
    tick(1);
    retire_a = 4'b0000;
    drv_a("instret_h2_second", SysopRdinstret, 2);
    tick(1);
    check("b2b_valid_2", 64'(rsp_valid_a), 64'd1);
    drv_a("instret_h0", SysopRdinstret, 0);
    tick(1);
    drv_a("rdtime_a", SysopRdtime, 1);
    tick(1);
    req_valid_a = 1'b0;
    tick(1);

    // Backpressure: response frozen for 3 cycles, then drained with SBREAK on the same edge.
    drv_a("bp_rdcycle", SysopRdcycle, 3);
    held = q_a[$].data;
    tick(1);
    req_valid_a = 1'b0;
    rsp_ready_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_req_ready", 64'(req_ready_a), 64'd0);
      check("bp_valid",     64'(rsp_valid_a), 64'd1);
      check("bp_data",      64'(rsp_data_a),  64'(held));
      check("bp_hart",      64'(rsp_hart_a),  64'd3);
      tick(1);
    end
    rsp_ready_a = 1'b1;
    drv_a("sbreak", SysopSbreak, 1);
    #1;
    check("bp_release_ready", 64'(req_ready_a), 64'd1);
    tick(1);
    check("sbreak_no_bubble", 64'(rsp_valid_a), 64'd1);
    drv_a("scall", SysopScall, 2);
    tick(1);
    req_valid_a = 1'b0;
    tick(1);

    // Reset while a response is held: it must vanish before the next edge.
    req_valid_a = 1'b1;
    req_sysop_a = SysopRdtime;
    req_hart_a  = 2'd1;
    tick(1);
    req_valid_a = 1'b0;
    rsp_ready_a = 1'b0;
    check("pre_rst_valid", 64'(rsp_valid_a), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(rsp_valid_a), 64'd0);
    check("async_rst_data",  64'(rsp_data_a),  64'd0);
    tick(1);
    rst_n       = 1'b1;
    rsp_ready_a = 1'b1;
    for (int h = 0; h < 4; h++) begin
      drv_a($sformatf("post_rst_instret_h%0d", h), SysopRdinstret, h);
      tick(1);
    end
    req_valid_a = 1'b0;

    // Small instance: prescaled time, out-of-range hart and 8-bit wrap.
    retire_b = 5'b11111;
    tick(3);
    retire_b = 5'b00000;
    while (edges < 40) tick(1);
    drv_b("time_at40", SysopRdtime, 0);
    tick(1);
    req_valid_b = 1'b0;
    tick(2);
    drv_b("time_at43", SysopRdtime, 0);
    tick(1);
    drv_b("instret_h5", SysopRdinstret, 5);
    tick(1);
    drv_b("instret_h1_b", SysopRdinstret, 1);
    tick(1);
    drv_b("instret_h4_b", SysopRdinstret, 4);
    tick(1);
    req_valid_b = 1'b0;
    while (edges < 260) tick(1);
    drv_b("wrap_cycle", SysopRdcycle, 0);
    tick(1);
    drv_b("wrap_cycleh", SysopRdcycleh, 0);
    tick(1);
    drv_b("wrap_time", SysopRdtime, 2);
    drv_a("late_time_a", SysopRdtime, 0);
    tick(1);
    req_valid_b = 1'b0;
    req_valid_a = 1'b0;
    tick(2);

    check("a_queue_drained", 64'(q_a.size()), 64'd0);
    check("b_queue_drained", 64'(q_b.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
